// File: rtl/uart_rx_word.sv
// UART receiver for 32-bit word frames: start bit, WORD_BITS data bits LSB first, stop bit.
// Each word is presented on a valid/ready holding register, with framing-error and overrun pulses.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | line idle, waiting for a low level on rx_s
// S_START     | counting to mid start bit, then confirm it is still low
// S_DATA      | sampling WORD_BITS data bits one bit period apart
// S_STOP      | sampling the stop bit one bit period after the last data bit
// S_WAIT_HIGH | bad stop bit seen; wait for the line to return high
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 86,
    parameter int WORD_BITS    = 32
) (
    input  logic                 iclk,
    input  logic                 irst_n,
    input  logic                 rx_serial,
    input  logic                 rx_data_ready,
    output logic [WORD_BITS-1:0] rx_byte,
    output logic                 rx_data_valid,
    output logic                 rx_active,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [4:0]    BIT_LAST = 5'(WORD_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 sync1;
    logic                 rx_s;
    logic [CW-1:0]        clk_cnt;
    logic [CW-1:0]        clk_cnt_nxt;
    logic [4:0]           bit_idx;
    logic [4:0]           bit_idx_nxt;
    logic [WORD_BITS-1:0] shift;
    logic                 sample_bit;
    logic                 good_stop;
    logic                 bad_stop;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_serial;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            clk_cnt <= clk_cnt_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_idx_nxt = bit_idx;
        sample_bit  = 1'b0;
        good_stop   = 1'b0;
        bad_stop    = 1'b0;
        case (state)
            S_IDLE: begin
                clk_cnt_nxt = '0;
                bit_idx_nxt = '0;
                if (!rx_s) state_nxt = S_START;
            end
            S_START: begin
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_nxt = '0;
                    // A start bit that is high again at mid-bit is treated as line noise.
                    state_nxt   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt = '0;
                    sample_bit  = 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        bit_idx_nxt = '0;
                        state_nxt   = S_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt = '0;
                    if (rx_s) begin
                        good_stop = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        bad_stop  = 1'b1;
                        state_nxt = S_WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            shift <= '0;
        end else begin
            for (int i = 0; i < WORD_BITS; i++) begin
                if (sample_bit && (bit_idx == 5'(i))) shift[i] <= rx_s;
            end
        end
    end

    // A full holding register accepts a new word only if it is being drained this same cycle.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            rx_byte       <= '0;
            rx_data_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_frame_err <= bad_stop;
            rx_overrun   <= 1'b0;
            if (good_stop && (!rx_data_valid || rx_data_ready)) begin
                rx_byte       <= shift;
                rx_data_valid <= 1'b1;
            end else if (good_stop) begin
                rx_overrun <= 1'b1;
            end else if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end
        end
    end

    assign rx_active = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_word.sv
// Self-checking bench for uart_rx_word: serialises words cycle by cycle and compares the
// receiver against a holding-register model and the frame latency formula.
module tb_uart_rx_word;

    localparam int CPB = 86;
    localparam int WB  = 32;
    localparam int LAT = 2 + (CPB - 1) / 2 + 1 + (WB + 1) * CPB + 1;

    logic          iclk = 1'b0;
    logic          irst_n = 1'b1;
    logic          rx_serial = 1'b1;
    logic          rx_data_ready = 1'b0;
    logic [WB-1:0] rx_byte;
    logic          rx_data_valid;
    logic          rx_active;
    logic          rx_frame_err;
    logic          rx_overrun;

    uart_rx_word #(.CLKS_PER_BIT(CPB), .WORD_BITS(WB)) dut (
        .iclk          (iclk),
        .irst_n        (irst_n),
        .rx_serial     (rx_serial),
        .rx_data_ready (rx_data_ready),
        .rx_byte       (rx_byte),
        .rx_data_valid (rx_data_valid),
        .rx_active     (rx_active),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int t_start = 0;
    int err_cnt = 0, ovr_cnt = 0, ovr_cyc = 0, act_cnt = 0, both_cnt = 0;
    int rise_cnt = 0, rise_cyc = 0, fall_cnt = 0;
    logic prev_valid = 1'b0;

    always @(negedge iclk) begin
        if (rx_frame_err) err_cnt++;
        if (rx_overrun) begin
            ovr_cnt++;
            ovr_cyc = cyc;
        end
        if (rx_active) act_cnt++;
        if (rx_frame_err && rx_overrun) both_cnt++;
        if (rx_data_valid && !prev_valid) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        if (!rx_data_valid && prev_valid) fall_cnt++;
        prev_valid = rx_data_valid;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask

    task automatic settle();
        @(negedge iclk);
        #1;
    endtask

    // Drives one frame, one loop pass per clock; ready_at / abort_at are cycle offsets (-1 = none).
    task automatic send_frame(input logic [31:0] word, input logic stop_val,
                              input int ready_at, input int abort_at);
        for (int c = 0; c < (WB + 2) * CPB; c++) begin
            int b;
            if (c == abort_at) return;
            @(posedge iclk);
            #1;
            if (c == 0) t_start = cyc;
            b = c / CPB;
            if (b == 0) rx_serial = 1'b0;
            else if (b <= WB) rx_serial = word[b-1];
            else rx_serial = stop_val;
            rx_data_ready = (c == ready_at);
        end
    endtask

    task automatic accept(input string name);
        @(posedge iclk);
        #1 rx_data_ready = 1'b1;
        @(posedge iclk);
        #1 rx_data_ready = 1'b0;
        settle();
        total++;
        if (rx_data_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_drop: valid got %b want 0", name, rx_data_valid);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if (rx_byte !== '0 || rx_data_valid !== 1'b0 || rx_active !== 1'b0 ||
            rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
            bad++;
            $display("FAIL %s: byte=%h valid=%b active=%b ferr=%b ovr=%b want all 0",
                     name, rx_byte, rx_data_valid, rx_active, rx_frame_err, rx_overrun);
        end
    endtask

    task automatic test_reset();
        #1 irst_n = 1'b0;
        cycles(3);
        settle();
        check_idle_outputs("reset_outputs");
        @(posedge iclk);
        #1 irst_n = 1'b1;
        cycles(5);
        settle();
        check_idle_outputs("after_reset_outputs");
    endtask

    task automatic test_single();
        int r0 = rise_cnt, e0 = err_cnt, o0 = ovr_cnt;
        send_frame(32'hA5C30F96, 1'b1, -1, -1);
        settle();
        total++;
        if (rise_cnt - r0 !== 1) begin
            bad++;
            $display("FAIL single_rise: got %0d rises want 1", rise_cnt - r0);
        end
        total++;
        if (rise_cyc - t_start < LAT - 1 || rise_cyc - t_start > LAT + 1) begin
            bad++;
            $display("FAIL single_latency: got %0d want %0d+-1", rise_cyc - t_start, LAT);
        end
        total++;
        if (rx_byte !== 32'hA5C30F96) begin
            bad++;
            $display("FAIL single_byte: got %h want a5c30f96", rx_byte);
        end
        cycles(200);
        settle();
        total++;
        if (rx_data_valid !== 1'b1) begin
            bad++;
            $display("FAIL single_hold: valid got %b want 1", rx_data_valid);
        end
        accept("single");
        total++;
        if (err_cnt != e0 || ovr_cnt != o0) begin
            bad++;
            $display("FAIL single_pulses: ferr=%0d ovr=%0d want 0 0", err_cnt - e0, ovr_cnt - o0);
        end
    endtask

    task automatic test_glitch();
        int r0 = rise_cnt, e0 = err_cnt, a0 = act_cnt;
        @(posedge iclk);
        #1 rx_serial = 1'b0;
        cycles(20);
        rx_serial = 1'b1;
        cycles(100);
        settle();
        total++;
        if (act_cnt == a0 || rx_active !== 1'b0) begin
            bad++;
            $display("FAIL glitch_active: active cycles %0d, now %b want >0 and 0", act_cnt - a0, rx_active);
        end
        total++;
        if (rise_cnt != r0 || err_cnt != e0) begin
            bad++;
            $display("FAIL glitch_pulses: valid rises %0d ferr %0d want 0 0", rise_cnt - r0, err_cnt - e0);
        end
    endtask

    task automatic test_frame_err();
        int r0 = rise_cnt, e0 = err_cnt;
        send_frame(32'h12345678, 1'b0, -1, -1);
        cycles(500);
        settle();
        total++;
        if (rx_active !== 1'b1 || rise_cnt != r0) begin
            bad++;
            $display("FAIL break_hold: active %b rises %0d want 1 0", rx_active, rise_cnt - r0);
        end
        rx_serial = 1'b1;
        cycles(2 * CPB);
        send_frame(32'h0000FFFF, 1'b1, -1, -1);
        settle();
        total++;
        if (err_cnt - e0 !== 1) begin
            bad++;
            $display("FAIL ferr_count: got %0d want 1", err_cnt - e0);
        end
        total++;
        if (rise_cnt - r0 !== 1 || rx_byte !== 32'h0000FFFF) begin
            bad++;
            $display("FAIL ferr_next_word: rises %0d byte %h want 1 0000ffff", rise_cnt - r0, rx_byte);
        end
        accept("ferr");
    endtask

    task automatic test_overrun();
        int r0 = rise_cnt, f0 = fall_cnt, o0 = ovr_cnt;
        send_frame(32'h11111111, 1'b1, -1, -1);
        send_frame(32'h22222222, 1'b1, -1, -1);
        settle();
        total++;
        if (ovr_cnt - o0 !== 1 || ovr_cyc - t_start !== LAT) begin
            bad++;
            $display("FAIL overrun_pulse: count %0d at %0d want 1 at %0d", ovr_cnt - o0, ovr_cyc - t_start, LAT);
        end
        total++;
        if (rx_byte !== 32'h11111111 || rx_data_valid !== 1'b1 || fall_cnt != f0 || rise_cnt - r0 !== 1) begin
            bad++;
            $display("FAIL overrun_hold: byte %h valid %b falls %0d want 11111111 1 0",
                     rx_byte, rx_data_valid, fall_cnt - f0);
        end
        accept("overrun");
    endtask

    task automatic test_back_to_back();
        int r0 = rise_cnt, f0 = fall_cnt, o0 = ovr_cnt;
        send_frame(32'h11111111, 1'b1, -1, -1);
        send_frame(32'h22222222, 1'b1, LAT - 1, -1);
        settle();
        total++;
        if (ovr_cnt != o0 || fall_cnt != f0 || rise_cnt - r0 !== 1) begin
            bad++;
            $display("FAIL b2b_flags: ovr %0d falls %0d rises %0d want 0 0 1",
                     ovr_cnt - o0, fall_cnt - f0, rise_cnt - r0);
        end
        total++;
        if (rx_byte !== 32'h22222222 || rx_data_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_word: byte %h valid %b want 22222222 1", rx_byte, rx_data_valid);
        end
        accept("b2b");
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [31:0] model_hold = 32'h22222222;
        logic        model_valid = 1'b0;
        int          model_ovr = 0;
        int          o0 = ovr_cnt;
        for (int i = 0; i < 5; i++) begin
            bit rdy;
            w   = $urandom;
            rdy = 1'($urandom_range(0, 1));
            cycles($urandom_range(0, 40));
            send_frame(w, 1'b1, rdy ? LAT - 1 : -1, -1);
            if (!model_valid || rdy) begin
                model_hold  = w;
                model_valid = 1'b1;
            end else begin
                model_ovr++;
            end
            settle();
            total++;
            if (rx_byte !== model_hold || rx_data_valid !== model_valid || ovr_cnt - o0 != model_ovr) begin
                bad++;
                $display("FAIL random_%0d: byte %h valid %b ovr %0d want %h %b %0d", i,
                         rx_byte, rx_data_valid, ovr_cnt - o0, model_hold, model_valid, model_ovr);
            end
        end
        accept("random");
    endtask

    task automatic test_reset_midframe();
        int r0 = rise_cnt, e0 = err_cnt, o0 = ovr_cnt;
        send_frame($urandom, 1'b1, -1, CPB * 11 + CPB / 2);
        irst_n    = 1'b0;
        rx_serial = 1'b1;
        settle();
        check_idle_outputs("midframe_reset_outputs");
        cycles(3);
        irst_n = 1'b1;
        cycles(2 * CPB);
        settle();
        total++;
        if (rx_data_valid !== 1'b0 || rise_cnt != r0 || err_cnt != e0 || ovr_cnt != o0) begin
            bad++;
            $display("FAIL midframe_abort: valid %b rises %0d ferr %0d ovr %0d want 0 0 0 0",
                     rx_data_valid, rise_cnt - r0, err_cnt - e0, ovr_cnt - o0);
        end
        send_frame(32'hDEADBEEF, 1'b1, -1, -1);
        settle();
        total++;
        if (rx_byte !== 32'hDEADBEEF || rise_cnt - r0 !== 1 ||
            rise_cyc - t_start < LAT - 1 || rise_cyc - t_start > LAT + 1) begin
            bad++;
            $display("FAIL midframe_next: byte %h rises %0d latency %0d want deadbeef 1 %0d",
                     rx_byte, rise_cnt - r0, rise_cyc - t_start, LAT);
        end
        accept("midframe");
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        total++;
        if (both_cnt != 0) begin
            bad++;
            $display("FAIL pulse_exclusive: ferr and ovr together %0d cycles want 0", both_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
